// File: rtl/register_pipeline_pkg.sv
// Shared constants and helpers for the handshaked register pipeline.
package register_pipeline_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 3;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned count_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_pipeline_stage.sv
// One data+valid pipeline register with load enable, synchronous reset and flush.
module register_pipeline_stage
  import register_pipeline_pkg::*;
#(
  parameter int unsigned        WIDTH = DefaultWidth,
  parameter logic [WIDTH-1:0]   INIT  = '0
) (
  input  logic             real_clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Flush only drops the valid bit; data is left as-is.
  always_ff @(posedge real_clk) begin
    if (rst) begin
      q       <= INIT;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/register_pipeline_vr.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, clock enable,
// synchronous flush and occupancy count.
module register_pipeline_vr
  import register_pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH = DefaultWidth,
  parameter int unsigned      DEPTH = DefaultDepth,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CE,
  input  logic                          FLUSH,
  input  logic [WIDTH-1:0]              I,
  input  logic                          I_valid,
  output logic                          I_ready,
  output logic [WIDTH-1:0]              O,
  output logic                          O_valid,
  input  logic                          O_ready,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int unsigned CntW = count_width(DEPTH);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load;
  logic             enable;
  logic             in_acc;
  logic             out_acc;
  logic [CntW-1:0]  count_q;

  assign enable = CE & ~FLUSH;

  // A stage can take a word if it is empty or everything downstream can move.
  always_comb begin : ready_chain
    logic r;
    r   = O_ready;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r      = ~valid[k] | r;
      rdy[k] = r;
    end
  end

  assign load    = {DEPTH{enable}} & rdy;
  assign I_ready = enable & rdy[0];
  assign O       = data[DEPTH-1];
  assign O_valid = valid[DEPTH-1];
  assign in_acc  = I_valid & I_ready;
  assign out_acc = enable & O_valid & O_ready;
  assign count   = count_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src;
    logic             src_valid;

    if (k == 0) begin : g_head
      assign src       = I;
      assign src_valid = I_valid;
    end else begin : g_body
      assign src       = data[k-1];
      assign src_valid = valid[k-1];
    end

    register_pipeline_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .real_clk (CLK),
      .rst      (RESET),
      .flush    (FLUSH),
      .load     (load[k]),
      .d        (src),
      .d_valid  (src_valid),
      .q        (data[k]),
      .q_valid  (valid[k])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      count_q <= '0;
    end else if (in_acc && !out_acc) begin
      count_q <= count_q + CntW'(1);
    end else if (out_acc && !in_acc) begin
      count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: tb/tb_register_pipeline_vr.sv
// Self-checking bench: directed vector table, hand sequences and a randomized queue model.
module tb_register_pipeline_vr;

  localparam int unsigned     W    = 8;
  localparam int unsigned     D    = 3;
  localparam logic [W-1:0]    INIT = 8'h5A;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1, CE = 1'b1, FLUSH = 1'b0, I_valid = 1'b0, O_ready = 1'b0;
  logic [W-1:0] I = '0;
  logic         I_ready, O_valid;
  logic [W-1:0] O;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  register_pipeline_vr #(
    .WIDTH (W),
    .DEPTH (D),
    .INIT  (INIT)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (CE),
    .FLUSH   (FLUSH),
    .I       (I),
    .I_valid (I_valid),
    .I_ready (I_ready),
    .O       (O),
    .O_valid (O_valid),
    .O_ready (O_ready),
    .count   (count)
  );

  typedef struct {
    logic         rst, ce, fl;
    logic [W-1:0] i;
    logic         iv, ordy;
    logic         chk, ir, ov, chk_o;
    logic [W-1:0] o;
    logic [1:0]   cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ce, logic fl, logic [W-1:0] i, logic iv,
                              logic ordy, logic chk, logic ir, logic ov, logic chk_o,
                              logic [W-1:0] o, logic [1:0] cnt);
    vec_t v;
    v.rst = rst; v.ce = ce; v.fl = fl; v.i = i; v.iv = iv; v.ordy = ordy;
    v.chk = chk; v.ir = ir; v.ov = ov; v.chk_o = chk_o; v.o = o; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; drives, checks, then advances one clock.
  task automatic run_vec(vec_t v, string tag);
    RESET = v.rst; CE = v.ce; FLUSH = v.fl; I = v.i; I_valid = v.iv; O_ready = v.ordy;
    #1;
    if (v.chk) begin
      chk({tag, ".I_ready"}, 32'(I_ready), 32'(v.ir));
      chk({tag, ".O_valid"}, 32'(O_valid), 32'(v.ov));
      chk({tag, ".count"},   32'(count),   32'(v.cnt));
      if (v.chk_o) chk({tag, ".O"}, 32'(O), 32'(v.o));
    end
    @(negedge CLK);
  endtask

  vec_t vecs [13];

  // Reference model: words in arrival order with their stage index.
  logic [W-1:0] m_data [$];
  int           m_pos  [$];
  int           limit;
  logic         m_in, e_ir, e_ov;
  logic         r_rst, r_ce, r_fl, r_iv, r_ordy;
  logic [W-1:0] r_i;

  initial begin
    // Reset, idle, then stream 01..06 with O_ready high and drain.
    vecs[0]  = mk(1, 1, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(1, 1, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 1, INIT,  0);
    vecs[3]  = mk(0, 1, 0, 8'h01, 1, 1,  1, 1, 0, 0, 8'h00, 0);
    vecs[4]  = mk(0, 1, 0, 8'h02, 1, 1,  1, 1, 0, 0, 8'h00, 1);
    vecs[5]  = mk(0, 1, 0, 8'h03, 1, 1,  1, 1, 0, 0, 8'h00, 2);
    vecs[6]  = mk(0, 1, 0, 8'h04, 1, 1,  1, 1, 1, 1, 8'h01, 3);
    vecs[7]  = mk(0, 1, 0, 8'h05, 1, 1,  1, 1, 1, 1, 8'h02, 3);
    vecs[8]  = mk(0, 1, 0, 8'h06, 1, 1,  1, 1, 1, 1, 8'h03, 3);
    vecs[9]  = mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h04, 3);
    vecs[10] = mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h05, 2);
    vecs[11] = mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h06, 1);
    vecs[12] = mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 0, 8'h00, 0);

    @(negedge CLK);
    for (int n = 0; n < 13; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Back-pressure with a bubble that collapses, then back-to-back drain.
    run_vec(mk(0, 1, 0, 8'h10, 1, 0,  1, 1, 0, 0, 8'h00, 0), "bp0");
    run_vec(mk(0, 1, 0, 8'h00, 0, 0,  1, 1, 0, 0, 8'h00, 1), "bp1");
    run_vec(mk(0, 1, 0, 8'h11, 1, 0,  1, 1, 0, 0, 8'h00, 1), "bp2");
    run_vec(mk(0, 1, 0, 8'h12, 1, 0,  1, 1, 1, 1, 8'h10, 2), "bp3");
    run_vec(mk(0, 1, 0, 8'h13, 1, 0,  1, 0, 1, 1, 8'h10, 3), "bp4");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h10, 3), "bp5");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h11, 2), "bp6");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h12, 1), "bp7");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 0, 8'h00, 0), "bp8");

    // Full pipe with simultaneous accept on both ends.
    run_vec(mk(0, 1, 0, 8'h1A, 1, 0,  1, 1, 0, 0, 8'h00, 0), "fs0");
    run_vec(mk(0, 1, 0, 8'h1B, 1, 0,  1, 1, 0, 0, 8'h00, 1), "fs1");
    run_vec(mk(0, 1, 0, 8'h1C, 1, 0,  1, 1, 0, 0, 8'h00, 2), "fs2");
    run_vec(mk(0, 1, 0, 8'h20, 1, 1,  1, 1, 1, 1, 8'h1A, 3), "fs3");
    run_vec(mk(0, 1, 0, 8'h00, 0, 0,  1, 0, 1, 1, 8'h1B, 3), "fs4");

    // CE low for 4 cycles while both sides want to move.
    for (int n = 0; n < 4; n++)
      run_vec(mk(0, 0, 0, 8'h30, 1, 1,  1, 0, 1, 1, 8'h1B, 3), $sformatf("ce%0d", n));
    run_vec(mk(0, 1, 0, 8'h30, 1, 1,  1, 1, 1, 1, 8'h1B, 3), "ce4");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h1C, 3), "ce5");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h20, 2), "ce6");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 1, 1, 8'h30, 1), "ce7");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 0, 8'h00, 0), "ce8");

    // Flush keeps data, reset+flush restores INIT.
    run_vec(mk(0, 1, 0, 8'h40, 1, 0,  1, 1, 0, 0, 8'h00, 0), "fl0");
    run_vec(mk(0, 1, 0, 8'h41, 1, 0,  1, 1, 0, 0, 8'h00, 1), "fl1");
    run_vec(mk(0, 1, 0, 8'h00, 0, 0,  1, 1, 0, 0, 8'h00, 2), "fl2");
    run_vec(mk(0, 1, 1, 8'h00, 0, 1,  1, 0, 1, 1, 8'h40, 2), "fl3");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 1, 8'h40, 0), "fl4");
    run_vec(mk(1, 1, 1, 8'h00, 0, 1,  0, 0, 0, 0, 8'h00, 0), "fl5");
    run_vec(mk(0, 1, 0, 8'h00, 0, 1,  1, 1, 0, 1, INIT,  0), "fl6");

    // Randomized traffic against the queue model; pipe is empty here.
    for (int n = 0; n < 2000; n++) begin
      r_rst  = ($urandom % 150) == 0;
      r_ce   = ($urandom % 6) != 0;
      r_fl   = ($urandom % 40) == 0;
      r_iv   = $urandom % 2;
      r_ordy = ($urandom % 3) != 0;
      r_i    = W'($urandom);
      RESET = r_rst; CE = r_ce; FLUSH = r_fl; I = r_i; I_valid = r_iv; O_ready = r_ordy;
      #1;
      e_ir = r_ce && !r_fl && (m_data.size() < D || r_ordy);
      e_ov = m_pos.size() > 0 && m_pos[0] == D - 1;
      chk($sformatf("rnd%0d.I_ready", n), 32'(I_ready), 32'(e_ir));
      chk($sformatf("rnd%0d.O_valid", n), 32'(O_valid), 32'(e_ov));
      chk($sformatf("rnd%0d.count", n),   32'(count),   32'(m_data.size()));
      if (e_ov) chk($sformatf("rnd%0d.O", n), 32'(O), 32'(m_data[0]));

      if (r_rst || r_fl) begin
        m_data.delete();
        m_pos.delete();
      end else if (r_ce) begin
        m_in  = r_iv && (m_data.size() < D || r_ordy);
        // Each word steps forward unless the slot ahead is still held after the word ahead moved.
        limit = r_ordy ? D + 1 : D;
        foreach (m_pos[j]) begin
          if (m_pos[j] + 1 < limit) m_pos[j] = m_pos[j] + 1;
          limit = m_pos[j];
        end
        if (m_pos.size() > 0 && m_pos[0] == D) begin
          void'(m_pos.pop_front());
          void'(m_data.pop_front());
        end
        if (m_in) begin
          m_data.push_back(r_i);
          m_pos.push_back(0);
        end
      end
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_pipeline_vr.md
Name: register_pipeline_vr

Overview:
Parametrised successor to the single clock-enabled register. A DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake on both ends, bubble collapsing, global clock enable, synchronous flush and occupancy count. It is used to retime datapaths where downstream back-pressure must be absorbed without losing words.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1; DEPTH=1 is a single handshaked register)
- INIT, 0, data value loaded into every stage on reset (WIDTH bits)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous active-high reset
- CE  in  1  clock enable; when 0 no stage changes and no handshake completes
- FLUSH  in  1  synchronous clear of all valid bits
- I  in  WIDTH  input data
- I_valid  in  1  input word present
- I_ready  out  1  pipeline accepts I this cycle
- O  out  WIDTH  data of last stage (meaningful only when O_valid=1)
- O_valid  out  1  last stage holds a word
- O_ready  in  1  consumer accepts O this cycle
- count  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State: data[k], valid[k] for k=0..DEPTH-1; stage DEPTH-1 drives O/O_valid.
- Reset (RESET=1 at edge, regardless of CE/FLUSH): all valid=0, all data=INIT, count=0. After reset: O=INIT, O_valid=0, I_ready=CE&~FLUSH.
- Priority: RESET > FLUSH > CE-gated operation.
- Ready chain (combinational): rdy[DEPTH]=O_ready; rdy[k]=~valid[k] | rdy[k+1]. I_ready=CE & ~FLUSH & rdy[0].
- Transfers: input accept = I_valid & I_ready; output accept = CE & ~FLUSH & O_valid & O_ready.
- Stage k loads (data[k]<=src, valid[k]<=src_valid) when CE & ~FLUSH & rdy[k]; src is I/I_valid for k=0, stage k-1 otherwise. Otherwise the stage holds. Data is loaded even when src_valid=0; stale data in invalid stages is don't-care except O after reset.
- Bubble collapse: an empty stage always accepts, so gaps close while output is stalled.
- Latency: into an empty pipe, a word accepted at edge t gives O_valid=1 in the cycle after edge t+DEPTH-1 (DEPTH cycles). Throughput is 1 word/cycle while O_ready=1.
- Full (count=DEPTH) and O_ready=0: I_ready=0; all state holds.
- Full and O_ready=1: simultaneous in/out accept; count is unchanged.
- count: +1 on input accept only, -1 on output accept only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- FLUSH=1 at edge: all valid=0, count=0, data unchanged. I_ready=0 and no output accept that cycle (the in-flight O word is dropped).
- CE=0: I_ready=0, O/O_valid/count hold and remain visible, and no output accept occurs even if O_ready=1.
- Reset mid-stream: all words are discarded and behaviour is identical to power-on.
- I_valid/O_ready are not required to be stable; there is no protocol checking in RTL.

Decomposition:
- Package register_pipeline_pkg: count width function (clog2(DEPTH+1)) and default parameter constants.
- Sub-module register_pipeline_stage (WIDTH, INIT): one data+valid register with load enable, sync reset and flush; instantiated DEPTH times by a generate loop. The top level owns the ready chain and the count.

Test Plan:
- Reset/idle: WIDTH=8, DEPTH=3, INIT=0x5A; assert RESET 2 cycles -> O=0x5A, O_valid=0, count=0, I_ready=1 (CE=1).
- Streaming: O_ready=1, I_valid=1, I=0x01,0x02,0x03,... from cycle 0 -> O_valid first high at cycle 3 with O=0x01, then 0x02,0x03 on consecutive cycles; count holds at 3.
- Back-pressure/collapse: send 0x10, idle one cycle, send 0x11 and 0x12 with O_ready=0 -> count reaches 3 and I_ready=0. Release O_ready -> O=0x10,0x11,0x12 back-to-back with no bubble.
- Full simultaneous: pipe full, O_ready=1, I_valid=1, I=0x20 -> one word leaves and 0x20 enters in the same cycle, count stays 3.
- CE stall: mid-stream set CE=0 for 4 cycles with O_ready=1, I_valid=1 -> I_ready=0, O/O_valid/count frozen, no words lost or duplicated after CE returns.
- Flush vs reset: pipe holds 2 words; FLUSH 1 cycle -> count=0, O_valid=0, O keeps the last data. Assert RESET and FLUSH together -> O=INIT.
